// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// states, opcodes/functs, ALU codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12,
    S_JAL    = 4'd13,
    S_JR     = 4'd14,
    S_RSVD   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  typedef enum logic [1:0] {
    AC_ADD   = 2'd0,
    AC_SUB   = 2'd1,
    AC_RTYPE = 2'd2,
    AC_ITYPE = 2'd3
  } alu_cls_e;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_A     = 2'b01;
  localparam logic [1:0] SA_SHAMT = 2'b10;

  localparam logic [1:0] SB_B     = 2'b00;
  localparam logic [1:0] SB_FOUR  = 2'b01;
  localparam logic [1:0] SB_IMM   = 2'b10;
  localparam logic [1:0] SB_BROFF = 2'b11;

  localparam logic [1:0] PS_ALU    = 2'b00;
  localparam logic [1:0] PS_ALUOUT = 2'b01;
  localparam logic [1:0] PS_JUMP   = 2'b10;
  localparam logic [1:0] PS_REG    = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] MR_ALUOUT = 2'b00;
  localparam logic [1:0] MR_MDR    = 2'b01;
  localparam logic [1:0] MR_PC     = 2'b10;

  function automatic logic is_retire(state_e s);
    return (s == S_MEMWB) || (s == S_MEMWR) ||
           (s == S_RWB)   || (s == S_BRANCH) ||
           (s == S_IWB)   || (s == S_JUMP) ||
           (s == S_JAL)   || (s == S_JR);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder: alu class + op/funct -> alu_ctrl.
// Ports: cls, op, funct in; alu_ctrl out.
module mc_alu_dec
  import mc_pkg::*;
(
  input  alu_cls_e    cls,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (cls)
      AC_ADD: alu_ctrl = ALU_ADD;
      AC_SUB: alu_ctrl = ALU_SUB;
      AC_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_SLL:  alu_ctrl = ALU_SLL;
          FN_SRL:  alu_ctrl = ALU_SRL;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      AC_ITYPE:
        alu_ctrl = (op == OP_ORI) ? ALU_OR : ALU_ADD;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: sequences the shared datapath per opcode.
// Ports: clk/rstn, run, op/funct/zero in; datapath controls, state, illegal, instret out.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic             iord,
  output logic             mem_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_op,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  alu_cls_e         alu_cls;
  logic             legal;
  logic             retire;

  mc_alu_dec u_alu_dec (
    .cls      (alu_cls),
    .op       (op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl)
  );

  always_comb begin
    legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR,
          FN_SLT, FN_SLL, FN_SRL, FN_JR: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ORI, OP_J, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign retire = is_retire(state_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_ORI: state_d = S_IEXEC;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          default:        state_d = S_IDLE;
        endcase
        if (!legal) state_d = S_IDLE;
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_IDLE;
    endcase
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  always_comb begin
    illegal_d = (state_q == S_DECODE) && !legal;
    instret_d = instret_q;
    if (retire) instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    pc_we      = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = MR_ALUOUT;
    alu_src_a  = SA_PC;
    alu_src_b  = SB_B;
    ext_op     = 1'b0;
    pc_src     = PS_ALU;
    alu_cls    = AC_ADD;
    case (state_q)
      S_FETCH: begin
        ir_we     = 1'b1;
        alu_src_b = SB_FOUR;
        pc_we     = 1'b1;
      end
      S_DECODE: alu_src_b = SB_BROFF;
      S_MEMADR: begin
        alu_src_a = SA_A;
        alu_src_b = SB_IMM;
        ext_op    = 1'b1;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        rf_we      = 1'b1;
        mem_to_reg = MR_MDR;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_we = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = (funct == FN_SLL || funct == FN_SRL) ? SA_SHAMT : SA_A;
        alu_cls   = AC_RTYPE;
      end
      S_RWB: begin
        rf_we   = 1'b1;
        reg_dst = RD_RD;
      end
      S_BRANCH: begin
        alu_src_a = SA_A;
        alu_cls   = AC_SUB;
        pc_src    = PS_ALUOUT;
        pc_we     = (op == OP_BNE) ? ~zero : zero;
      end
      S_IEXEC: begin
        alu_src_a = SA_A;
        alu_src_b = SB_IMM;
        ext_op    = (op == OP_ADDI);
        alu_cls   = AC_ITYPE;
      end
      S_IWB: rf_we = 1'b1;
      S_JUMP: begin
        pc_src = PS_JUMP;
        pc_we  = 1'b1;
      end
      // Link writes PC+4: PC still holds it until this edge updates PC.
      S_JAL: begin
        pc_src     = PS_JUMP;
        pc_we      = 1'b1;
        rf_we      = 1'b1;
        reg_dst    = RD_RA;
        mem_to_reg = MR_PC;
      end
      S_JR: begin
        pc_src = PS_REG;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule
